// File: rtl/prio_pkg.sv
// Shared constants for the priority-encoder path and its capture front end.
package prio_pkg;
  localparam int PRIO_W = 16;
  localparam int IDX_W  = 4;
  localparam logic [7:0] PRIO_NONE = 8'hF0;

  typedef enum logic {
    CAP_LEVEL = 1'b0,
    CAP_EDGE  = 1'b1
  } cap_mode_e;
endpackage

// File: rtl/req_capture_sync_if.sv
// Control/status bundle between the capture stage and its driver/consumer.
interface req_capture_sync_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  import prio_pkg::*;

  logic [WIDTH-1:0] req_in;
  logic             edge_mode;
  logic [WIDTH-1:0] mask;
  logic             clr_valid;
  logic [IDX_W-1:0] clr_index;
  logic             stat_clr;
  logic [WIDTH-1:0] pending;
  logic             pending_any;
  logic [WIDTH-1:0] overrun;
  logic [CNT_W-1:0] evt_count;

  modport master (
    output req_in, edge_mode, mask, clr_valid, clr_index, stat_clr,
    input  pending, pending_any, overrun, evt_count
  );

  modport slave (
    input  req_in, edge_mode, mask, clr_valid, clr_index, stat_clr,
    output pending, pending_any, overrun, evt_count
  );
endinterface

// File: rtl/req_capture_sync_sync_bit.sv
// N-flop synchronizer for one asynchronous line; o_q is the last stage.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_chain <= '0;
    else     r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];
endmodule

// File: rtl/req_capture_sync.sv
// Request capture: sync async lines, detect edge/level events, hold them sticky
// for the encoder, retire by index, and track overrun/event statistics.
module req_capture_sync
  import prio_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  req_capture_sync_if.slave bus
);
  if (WIDTH < 1 || WIDTH > PRIO_W) begin : g_bad_width
    $error("req_capture_sync: WIDTH must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("req_capture_sync: SYNC_STAGES must be >= 2");
  end

  logic [WIDTH-1:0] w_req;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_ovr_set;
  logic [WIDTH-1:0] w_pend_nxt;
  logic             w_new;
  logic             w_cnt_full;
  cap_mode_e        w_mode;

  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_pending;
  logic             r_pending_any;
  logic [WIDTH-1:0] r_overrun;
  logic [CNT_W-1:0] r_cnt;

  assign w_req  = bus.req_in;
  assign w_mode = cap_mode_e'(bus.edge_mode);

  // Per-line synchronizer plus clear decode; out-of-range indices match no line.
  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (w_req[i]),
      .o_q (w_s[i])
    );
    assign w_clr[i] = bus.clr_valid & (bus.clr_index == IDX_W'(i));
  end

  assign w_set      = ~bus.mask & ((w_mode == CAP_EDGE) ? (w_s & ~r_p) : w_s);
  // Set beats a same-cycle clear so a fresh event is never dropped.
  assign w_pend_nxt = w_set | (r_pending & ~w_clr);
  assign w_ovr_set  = w_set & r_pending & ~w_clr;
  assign w_new      = |(w_set & ~r_pending);
  assign w_cnt_full = (r_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p           <= '0;
      r_pending     <= '0;
      r_pending_any <= 1'b0;
      r_overrun     <= '0;
      r_cnt         <= '0;
    end else begin
      r_p           <= w_s;
      r_pending     <= w_pend_nxt;
      r_pending_any <= |w_pend_nxt;
      // stat_clr wipes history but still records an overrun from this cycle.
      if (bus.stat_clr) begin
        r_overrun <= w_ovr_set;
        r_cnt     <= '0;
      end else begin
        r_overrun <= r_overrun | w_ovr_set;
        if (w_new && !w_cnt_full) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pending     = r_pending;
  assign bus.pending_any = r_pending_any;
  assign bus.overrun     = r_overrun;
  assign bus.evt_count   = r_cnt;
endmodule

// File: tb/tb_req_capture_sync.sv
// Directed bench: per-cycle vector table plus hand sequences for reset,
// out-of-range clear (WIDTH=12), counter saturation and level mode.
module tb_req_capture_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  req_capture_sync_if #(.WIDTH(16), .CNT_W(8)) ifa ();
  req_capture_sync_if #(.WIDTH(12), .CNT_W(8)) ifb ();

  req_capture_sync #(.WIDTH(16), .SYNC_STAGES(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  req_capture_sync #(.WIDTH(12), .SYNC_STAGES(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  typedef struct {
    logic [15:0] req;
    logic [15:0] mask;
    logic        cv;
    logic [3:0]  ci;
    logic        sc;
    logic [15:0] pend;
    logic [15:0] ovr;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tv[25];

  function automatic vec_t mk(logic [15:0] req, logic [15:0] mask, logic cv, logic [3:0] ci,
                              logic sc, logic [15:0] pend, logic [15:0] ovr, logic [7:0] cnt);
    vec_t v;
    v.req = req; v.mask = mask; v.cv = cv; v.ci = ci; v.sc = sc;
    v.pend = pend; v.ovr = ovr; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input int line);
    ifa.req_in[line] = 1'b1;
    step(); step();
    ifa.req_in[line] = 1'b0;
    repeat (4) step();
  endtask

  task automatic clear_a(input logic [3:0] idx);
    ifa.clr_valid = 1'b1;
    ifa.clr_index = idx;
    step();
    ifa.clr_valid = 1'b0;
  endtask

  initial begin
    ifa.req_in = '0; ifa.edge_mode = 1'b1; ifa.mask = '0;
    ifa.clr_valid = 1'b0; ifa.clr_index = '0; ifa.stat_clr = 1'b0;
    ifb.req_in = '0; ifb.edge_mode = 1'b1; ifb.mask = '0;
    ifb.clr_valid = 1'b0; ifb.clr_index = '0; ifb.stat_clr = 1'b0;

    tv[0]  = mk(16'h0020, 16'h0000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd0);
    tv[1]  = mk(16'h0020, 16'h0000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd0);
    tv[2]  = mk(16'h0020, 16'h0000, 0, 4'd0, 0, 16'h0020, 16'h0000, 8'd1);
    tv[3]  = mk(16'h0020, 16'h0000, 0, 4'd0, 0, 16'h0020, 16'h0000, 8'd1);
    tv[4]  = mk(16'h0020, 16'h0000, 1, 4'd5, 0, 16'h0000, 16'h0000, 8'd1);
    tv[5]  = mk(16'h0000, 16'h0000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd1);
    tv[6]  = mk(16'h0000, 16'h0000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd1);
    tv[7]  = mk(16'h0000, 16'h0000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd1);
    tv[8]  = mk(16'h0008, 16'h0000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd1);
    tv[9]  = mk(16'h0008, 16'h0000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd1);
    tv[10] = mk(16'h0000, 16'h0000, 0, 4'd0, 0, 16'h0008, 16'h0000, 8'd2);
    tv[11] = mk(16'h0000, 16'h0000, 0, 4'd0, 0, 16'h0008, 16'h0000, 8'd2);
    tv[12] = mk(16'h0008, 16'h0000, 0, 4'd0, 0, 16'h0008, 16'h0000, 8'd2);
    tv[13] = mk(16'h0008, 16'h0000, 0, 4'd0, 0, 16'h0008, 16'h0000, 8'd2);
    tv[14] = mk(16'h0000, 16'h0000, 1, 4'd3, 0, 16'h0008, 16'h0000, 8'd2);
    tv[15] = mk(16'h0000, 16'h0000, 0, 4'd0, 0, 16'h0008, 16'h0000, 8'd2);
    tv[16] = mk(16'h0008, 16'h0000, 0, 4'd0, 0, 16'h0008, 16'h0000, 8'd2);
    tv[17] = mk(16'h0008, 16'h0000, 0, 4'd0, 0, 16'h0008, 16'h0000, 8'd2);
    tv[18] = mk(16'h0000, 16'h0000, 0, 4'd0, 0, 16'h0008, 16'h0008, 8'd2);
    tv[19] = mk(16'h0000, 16'h0000, 0, 4'd0, 1, 16'h0008, 16'h0000, 8'd0);
    tv[20] = mk(16'h0000, 16'h0000, 1, 4'd3, 0, 16'h0000, 16'h0000, 8'd0);
    tv[21] = mk(16'h8000, 16'h8000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd0);
    tv[22] = mk(16'h8000, 16'h8000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd0);
    tv[23] = mk(16'h8000, 16'h8000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd0);
    tv[24] = mk(16'h8000, 16'h8000, 0, 4'd0, 0, 16'h0000, 16'h0000, 8'd0);

    // Reset state while rst is held.
    step();
    chk("rst_pending", 32'(ifa.pending), 32'h0);
    chk("rst_any", 32'(ifa.pending_any), 32'h0);
    chk("rst_evt", 32'(ifa.evt_count), 32'h0);
    #3 rst = 1'b0;
    step();

    for (int i = 0; i < 25; i++) begin
      ifa.req_in    = tv[i].req;
      ifa.mask      = tv[i].mask;
      ifa.clr_valid = tv[i].cv;
      ifa.clr_index = tv[i].ci;
      ifa.stat_clr  = tv[i].sc;
      step();
      chk($sformatf("v%0d_pending", i), 32'(ifa.pending), 32'(tv[i].pend));
      chk($sformatf("v%0d_any", i), 32'(ifa.pending_any), 32'(|tv[i].pend));
      chk($sformatf("v%0d_overrun", i), 32'(ifa.overrun), 32'(tv[i].ovr));
      chk($sformatf("v%0d_evt", i), 32'(ifa.evt_count), 32'(tv[i].cnt));
    end
    ifa.req_in = '0; ifa.clr_valid = 1'b0; ifa.stat_clr = 1'b0;
    repeat (4) step();
    ifa.mask = '0;
    step();
    chk("mask_idle_pending", 32'(ifa.pending), 32'h0);

    // WIDTH=12: out-of-range clears leave pending alone.
    ifb.req_in[0] = 1'b1;
    step(); step();
    ifb.req_in[0] = 1'b0;
    repeat (4) step();
    chk("w12_pending_set", 32'(ifb.pending), 32'h001);
    ifb.clr_valid = 1'b1; ifb.clr_index = 4'd13;
    step();
    chk("w12_clr13", 32'(ifb.pending), 32'h001);
    ifb.clr_index = 4'd12;
    step();
    chk("w12_clr12", 32'(ifb.pending), 32'h001);
    ifb.clr_index = 4'd0;
    step();
    ifb.clr_valid = 1'b0;
    chk("w12_clr0", 32'(ifb.pending), 32'h000);

    // Build pending=0009, evt_count=5, then async reset between edges.
    pulse_a(1); clear_a(4'd1);
    pulse_a(2); clear_a(4'd2);
    pulse_a(4); clear_a(4'd4);
    pulse_a(0);
    pulse_a(3);
    chk("pre_rst_pending", 32'(ifa.pending), 32'h0009);
    chk("pre_rst_evt", 32'(ifa.evt_count), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pending", 32'(ifa.pending), 32'h0);
    chk("async_rst_any", 32'(ifa.pending_any), 32'h0);
    chk("async_rst_overrun", 32'(ifa.overrun), 32'h0);
    chk("async_rst_evt", 32'(ifa.evt_count), 32'h0);
    #2 rst = 1'b0;
    step();

    // Counter saturation on line 0.
    for (int k = 1; k <= 300; k++) begin
      pulse_a(0);
      clear_a(4'd0);
      if (k == 254) chk("sat_254", 32'(ifa.evt_count), 32'hFE);
      if (k == 255) chk("sat_255", 32'(ifa.evt_count), 32'hFF);
    end
    chk("sat_300", 32'(ifa.evt_count), 32'hFF);
    chk("sat_overrun", 32'(ifa.overrun), 32'h0);
    ifa.stat_clr = 1'b1;
    step();
    ifa.stat_clr = 1'b0;
    chk("stat_clr_evt", 32'(ifa.evt_count), 32'h0);

    // Level mode: held line re-captures after a clear.
    ifa.edge_mode = 1'b0;
    ifa.req_in = 16'h0002;
    repeat (3) step();
    chk("lvl_pending", 32'(ifa.pending), 32'h0002);
    chk("lvl_evt", 32'(ifa.evt_count), 32'd1);
    clear_a(4'd1);
    chk("lvl_reset_after_clr", 32'(ifa.pending), 32'h0002);
    step();
    chk("lvl_evt_no_recount", 32'(ifa.evt_count), 32'd1);
    ifa.req_in = '0;
    repeat (3) step();
    clear_a(4'd1);
    chk("lvl_final_pending", 32'(ifa.pending), 32'h0);
    chk("lvl_final_any", 32'(ifa.pending_any), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/req_capture_sync.md
# req_capture_sync

Upstream capture stage for the priority encoder. Samples 16 asynchronous request lines, synchronizes them into `clk`, detects events (rising edge or level), and holds them in a sticky pending vector that drives the encoder's 16-bit input. The consumer of the encoder result returns the serviced index through a clear port, retiring that bit. The block also keeps per-bit overrun flags and a saturating event counter for debug readout.

## Interface
- `WIDTH`, default 16: number of request lines; must be ≤ 16.
- `SYNC_STAGES`, default 2: synchronizer flops per line; must be ≥ 2.
- `CNT_W`, default 8: event counter width.

- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous assert, active-high.
- `req_in` in WIDTH: raw asynchronous request lines.
- `edge_mode` in 1: 1 = capture on rising edge; 0 = capture while level high. Quasi-static.
- `mask` in WIDTH: 1 = line disabled for capture. Does not clear an existing pending bit.
- `clr_valid` in 1: one-cycle pulse to retire a serviced request.
- `clr_index` in 4: index to retire; ignored if ≥ WIDTH.
- `stat_clr` in 1: pulse; zeroes `overrun` and `evt_count`.
- `pending` out WIDTH: sticky request vector, registered; feeds the encoder.
- `pending_any` out 1: OR of `pending`, registered alongside it.
- `overrun` out WIDTH: sticky per-bit "event arrived while still pending".
- `evt_count` out CNT_W: saturating count of cycles with ≥1 new capture.

## Operation
- Reset: sync chain, edge-history register, `pending`, `pending_any`, `overrun` and `evt_count` all go to 0 immediately.
- Synchronized line `s[i]` is the last flop of the chain. Edge-history `p[i]` is `s[i]` delayed by 1.
- Capture term:
  - `set[i] = ~mask[i] & (edge_mode ? (s[i] & ~p[i]) : s[i])`.
- Clear term: `clr[i] = clr_valid & (clr_index == i)`.
- Next-state rules per bit:
  - pending: `pending[i] <= set[i] | (pending[i] & ~clr[i])`. Set wins over a same-cycle clear, so a new event is never lost.
  - overrun: sets when `set[i] & pending[i] & ~clr[i]`. Not flagged when the old event is retired in the same cycle. In level mode a held line re-sets every cycle, so `overrun` is meaningful only with `edge_mode=1`.
  - Clearing a non-pending bit has no effect.
- `evt_count` increments by 1 when `|(set & ~pending)` and the count is below all-ones. It holds at all-ones.
- `stat_clr` takes priority over a same-cycle increment or overrun set, except for a new overrun in that same cycle: clear first, then set.
- Changing `edge_mode` mid-operation does not alter `pending`. The first edge-mode cycle uses the valid `p`.

## Timing
- Latency from a `req_in` change to `pending`: `SYNC_STAGES`+1 rising edges. With the default this is 3 edges, for a change that is stable before edge 1.
- A clear pulse at edge k drops `pending[i]` and `pending_any` after edge k.
- The encoder path is purely combinational from `pending`. The encoder's index is therefore valid in the same cycle `pending` updates, and can be returned on `clr_index` for the next edge.
- Minimum pulse width on `req_in` for guaranteed capture: 2 clock periods. Shorter pulses may be missed, and that is legal behaviour.

## Structure
- Shared package `prio_pkg`:
  - `PRIO_W = 16`.
  - `IDX_W = 4`.
  - `PRIO_NONE = 8'hF0`, the encoder's no-request code. Consumers must not drive `clr_valid` when the code equals `PRIO_NONE`.
- One sub-module, `sync_bit`: an N-stage synchronizer with async active-high reset. It is instantiated WIDTH times, or once vectorized.
- The top-level TinyTapeout wrapper maps `ui_in`/`uio_in` onto `req_in`. It is not part of this block.

## Test plan
- Reset mid-operation: `pending=16'h0009` and `evt_count=5`, then pulse `rst` between edges. Required: all outputs are 0 immediately, before the next edge.
- Edge capture:
  - Stimulus: `edge_mode=1`; raise `req_in[5]` and hold it high.
  - Required: `pending=16'h0020` and `pending_any=1` after edge 3.
  - Required: `evt_count=1`, and no further increments while the line is held.
- Retire with simultaneous event:
  - Stimulus: `pending[3]=1`. A new edge on line 3 arrives in the same cycle as `clr_valid=1`, `clr_index=3`.
  - Required: `pending[3]` stays 1 and `overrun[3]` stays 0.
  - Follow-up: a second edge without a clear sets `overrun[3]=1`.
- Mask and out-of-range clear:
  - Stimulus: `mask=16'h8000` and edge on line 15. Required: `pending` stays 0.
  - Stimulus: with WIDTH=12, `clr_index=13` against `pending=12'h001`. Required: no change.
- Counter saturation: 300 separate edge events on line 0, each retired. Required: `evt_count` stops at 8'hFF. A `stat_clr` pulse then returns it to 0.
- Level mode:
  - Stimulus: `edge_mode=0` with `req_in[1]` held high; clear index 1.
  - Required: `pending[1]` is 1 again at the next edge.
  - Required: after `req_in[1]` drops, one clear leaves `pending=0`.
